// File: rtl/alisim_pkg.sv
// Shared definitions for the sequence-generation pipeline:
// nucleotide encodings, sampler FSM states and default random-value width.
package alisim_pkg;

  localparam int RAND_W_DEF = 10;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } sampler_state_t;

endpackage

// File: rtl/base_map.sv
// Combinational random value -> nucleotide map via three cumulative thresholds.
// Priority order A, C, G, T; non-monotonic thresholds resolve by that order.
module base_map
  import alisim_pkg::*;
#(
  parameter int RAND_W = RAND_W_DEF
) (
  input  logic [RAND_W-1:0] rand_val,
  input  logic [RAND_W-1:0] thr_a,
  input  logic [RAND_W-1:0] thr_c,
  input  logic [RAND_W-1:0] thr_g,
  output logic [1:0]        base
);

  always_comb begin
    base = BASE_T;
    if (rand_val < thr_a) begin
      base = BASE_A;
    end else if (rand_val < thr_c) begin
      base = BASE_C;
    end else if (rand_val < thr_g) begin
      base = BASE_G;
    end
  end

endmodule

// File: rtl/base_sampler.sv
// Seeds the LFSR, samples it once per free output slot and streams SEQ_LEN bases
// over valid/ready; first base 3 cycles after start, stalls skip LFSR values.
module base_sampler
  import alisim_pkg::*;
#(
  parameter int RAND_W  = RAND_W_DEF,
  parameter int SEQ_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [RAND_W-1:0] seed_in,
  input  logic [RAND_W-1:0] thr_a,
  input  logic [RAND_W-1:0] thr_c,
  input  logic [RAND_W-1:0] thr_g,
  input  logic [RAND_W-1:0] rand_val,
  output logic [RAND_W-1:0] lfsr_seed,
  output logic              lfsr_reseed_en,
  output logic [1:0]        base_out,
  output logic              base_valid,
  input  logic              base_ready,
  output logic              base_last,
  output logic              busy,
  output logic              done
);

  sampler_state_t    state, state_nxt;
  logic [RAND_W-1:0] seed_q, thr_a_q, thr_c_q, thr_g_q;
  logic [CNT_W-1:0]  count;
  logic [1:0]        base_mapped;
  logic              slot, accept, cnt_final;
  logic              capture, sample_en, drain_acc;

  base_map #(.RAND_W(RAND_W)) u_map (
    .rand_val (rand_val),
    .thr_a    (thr_a_q),
    .thr_c    (thr_c_q),
    .thr_g    (thr_g_q),
    .base     (base_mapped)
  );

  assign slot      = !base_valid || base_ready;
  assign accept    = base_valid && base_ready;
  assign cnt_final = (count == CNT_W'(SEQ_LEN - 1));

  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    sample_en      = 1'b0;
    drain_acc      = 1'b0;
    busy           = (state != ST_IDLE);
    lfsr_reseed_en = 1'b0;
    lfsr_seed      = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = ST_SEED;
        end
      end
      ST_SEED: begin
        lfsr_reseed_en = 1'b1;
        lfsr_seed      = seed_q;
        state_nxt      = ST_RUN;
      end
      ST_RUN: begin
        // A stalled slot leaves rand_val unsampled; the LFSR keeps running.
        if (slot) begin
          sample_en = 1'b1;
          if (cnt_final) begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          drain_acc = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_q     <= '0;
      thr_a_q    <= '0;
      thr_c_q    <= '0;
      thr_g_q    <= '0;
      count      <= '0;
      base_out   <= '0;
      base_valid <= 1'b0;
      base_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= drain_acc;
      if (capture) begin
        seed_q  <= seed_in;
        thr_a_q <= thr_a;
        thr_c_q <= thr_c;
        thr_g_q <= thr_g;
        count   <= '0;
      end
      if (sample_en) begin
        base_out   <= base_mapped;
        base_valid <= 1'b1;
        base_last  <= cnt_final;
        count      <= count + 1'b1;
      end
      if (drain_acc) begin
        base_valid <= 1'b0;
        base_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_base_sampler.sv
// Bench for base_sampler: stream-level scoreboard model plus directed scenarios
// with literal expectations for LFSR runs, threshold boundaries, stalls and reset.
module tb_base_sampler;
  import alisim_pkg::*;

  localparam int RW = 10;
  localparam int SL = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] seed_in = '0, thr_a = '0, thr_c = '0, thr_g = '0;
  logic [RW-1:0] rand_val, lfsr_seed;
  logic          lfsr_reseed_en, base_valid, base_last, busy, done;
  logic          base_ready = 1'b1;
  logic [1:0]    base_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Random source: LFSR stand-in reproducing the documented sequences, or a table.
  logic          use_tbl = 1'b0;
  logic [RW-1:0] lfsr_q = '0;
  int            tbl_idx = 0;
  logic [RW-1:0] tbl [8] = '{10'd0, 10'd255, 10'd256, 10'd511, 10'd512, 10'd767, 10'd768, 10'd1023};

  always @(posedge clk) begin
    if (lfsr_reseed_en) begin
      lfsr_q  <= lfsr_seed;
      tbl_idx <= 0;
    end else begin
      lfsr_q  <= {lfsr_q[RW-2:0], 1'b0};
      tbl_idx <= (tbl_idx + 1) % 8;
    end
  end
  assign rand_val = use_tbl ? tbl[tbl_idx] : lfsr_q;

  base_sampler #(.RAND_W(RW), .SEQ_LEN(SL), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .seed_in        (seed_in),
    .thr_a          (thr_a),
    .thr_c          (thr_c),
    .thr_g          (thr_g),
    .rand_val       (rand_val),
    .lfsr_seed      (lfsr_seed),
    .lfsr_reseed_en (lfsr_reseed_en),
    .base_out       (base_out),
    .base_valid     (base_valid),
    .base_ready     (base_ready),
    .base_last      (base_last),
    .busy           (busy),
    .done           (done)
  );

  function automatic logic [1:0] ref_map(input logic [RW-1:0] r, a, c, g);
    if (r < a) return 2'd0;
    if (r < c) return 2'd1;
    if (r < g) return 2'd2;
    return 2'd3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: queue of produced-but-unaccepted bases, bases still to draw, cycles since start.
  bit            m_act = 0, m_done = 0;
  int            m_t = 0, m_left = 0;
  logic [1:0]    q [$];
  logic [RW-1:0] m_seed, m_a, m_c, m_g;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_act = 0; m_done = 0; q.delete();
    end else begin
      m_done = 0;
      if (!m_act) begin
        if (start) begin
          m_act = 1; m_t = 0; m_left = SL;
          m_seed = seed_in; m_a = thr_a; m_c = thr_c; m_g = thr_g;
        end
      end else if (m_t == 0) begin
        m_t = 1;
      end else begin
        int  had;
        bit  acc;
        had = q.size();
        acc = (had > 0) && base_ready;
        if (acc) void'(q.pop_front());
        if (m_left > 0 && (had == 0 || base_ready)) begin
          q.push_back(ref_map(rand_val, m_a, m_c, m_g));
          m_left--;
        end
        if (acc && m_left == 0 && q.size() == 0) begin
          m_act = 0; m_done = 1;
        end
      end
    end
  end

  // Compare process: every cycle, plus a log of accepted beats {last, base}.
  logic [2:0] dut_log [$];
  logic       prev_vld = 1'b0, prev_last = 1'b0;
  logic [1:0] prev_out = '0;
  int         cyc = 0, last_acc_cyc = -1, done_cyc = -2;

  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (!reset_n) begin
      chk("rst_valid", base_valid, 0);
      chk("rst_base", base_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_reseed", lfsr_reseed_en, 0);
      prev_vld = 1'b0;
    end else begin
      bit rs;
      if (prev_vld && base_ready) begin
        dut_log.push_back({prev_last, prev_out});
        if (prev_last) last_acc_cyc = cyc;
      end
      rs = m_act && (m_t == 0);
      chk("valid", base_valid, q.size() > 0);
      if (q.size() > 0) chk("base_out", base_out, q[0]);
      chk("last", base_last, (q.size() == 1) && (m_left == 0));
      chk("busy", busy, m_act);
      chk("done", done, m_done);
      chk("reseed_en", lfsr_reseed_en, rs);
      chk("lfsr_seed", lfsr_seed, rs ? m_seed : '0);
      if (done) done_cyc = cyc;
      prev_vld = base_valid; prev_out = base_out; prev_last = base_last;
    end
  end

  task automatic run_seq(input logic [RW-1:0] seed, a, c, g);
    @(negedge clk);
    seed_in = seed; thr_a = a; thr_c = c; thr_g = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_done_seen"}, done, 1);
    @(negedge clk);
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (dut_log.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("log_reached", dut_log.size() >= n, 1);
  endtask

  // Count log entries that differ from the T x9, G, A... pattern of seed 3FF.
  function automatic int bad_3ff();
    int nb = 0;
    for (int i = 0; i < dut_log.size(); i++) begin
      logic [1:0] e;
      e = (i < 9) ? 2'd3 : (i == 9) ? 2'd2 : 2'd0;
      if (dut_log[i][1:0] !== e) nb++;
    end
    return nb;
  endfunction

  function automatic int bad_tbl(input int n);
    int nb = 0;
    for (int i = 0; i < n && i < dut_log.size(); i++) begin
      if (dut_log[i][1:0] !== 2'((i % 8) / 2)) nb++;
    end
    return nb;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", base_valid, 0);
    chk("reset_last", base_last, 0);
    chk("reset_done", done, 0);
    chk("reset_seed", lfsr_seed, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Seed 000: all A, latency 3, done right after the last accept.
    begin
      int lat, n_a, n_last;
      dut_log.delete();
      use_tbl = 1'b0;
      run_seq(10'h000, 10'd256, 10'd512, 10'd768);
      lat = 1;
      while (!base_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("latency", lat, 3);
      wait_done("seed0");
      n_a = 0; n_last = 0;
      foreach (dut_log[i]) begin
        if (dut_log[i][1:0] == 2'd0) n_a++;
        if (dut_log[i][2]) n_last++;
      end
      chk("seed0_count", dut_log.size(), 64);
      chk("seed0_all_A", n_a, 64);
      chk("seed0_one_last", n_last, 1);
      if (dut_log.size() == 64) chk("seed0_last_on_64th", dut_log[63][2], 1);
      chk("done_after_last", done_cyc, last_acc_cyc);
    end

    // Seed 3FF: T x9, G, then A.
    dut_log.delete();
    run_seq(10'h3FF, 10'd256, 10'd512, 10'd768);
    wait_done("seed3ff");
    chk("seed3ff_count", dut_log.size(), 64);
    chk("seed3ff_pattern_bad", bad_3ff(), 0);
    if (dut_log.size() > 10) begin
      chk("seed3ff_b0_T", dut_log[0][1:0], 3);
      chk("seed3ff_b9_G", dut_log[9][1:0], 2);
      chk("seed3ff_b10_A", dut_log[10][1:0], 0);
    end

    // Threshold boundaries 0,255,256,511,512,767,768,1023 -> A,A,C,C,G,G,T,T.
    dut_log.delete();
    use_tbl = 1'b1;
    run_seq(10'h000, 10'd256, 10'd512, 10'd768);
    wait_done("bound");
    chk("bound_count", dut_log.size(), 64);
    chk("bound_pattern_bad", bad_tbl(64), 0);
    if (dut_log.size() > 7) begin
      chk("bound_255_A", dut_log[1][1:0], 0);
      chk("bound_256_C", dut_log[2][1:0], 1);
      chk("bound_768_T", dut_log[6][1:0], 3);
    end

    // Backpressure: 5-cycle stall, then alternating ready.
    begin
      int n_before;
      dut_log.delete();
      run_seq(10'h000, 10'd256, 10'd512, 10'd768);
      wait_log(20);
      base_ready = 1'b0;
      n_before = dut_log.size();
      repeat (5) @(negedge clk);
      chk("stall_no_accept", dut_log.size(), n_before);
      for (int i = 0; i < 8; i++) begin
        base_ready = i[0];
        @(negedge clk);
      end
      base_ready = 1'b1;
      wait_done("stall");
      chk("stall_count", dut_log.size(), 64);
      chk("stall_prefix_bad", bad_tbl(20), 0);
    end

    // start and threshold changes while busy are ignored.
    dut_log.delete();
    use_tbl = 1'b0;
    run_seq(10'h3FF, 10'd256, 10'd512, 10'd768);
    repeat (3) @(negedge clk);
    thr_a = '0; thr_c = '0; thr_g = '0; seed_in = 10'h000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    chk("ignore_count", dut_log.size(), 64);
    chk("ignore_pattern_bad", bad_3ff(), 0);
    repeat (3) @(negedge clk);
    chk("ignore_idle_after", busy, 0);

    // Reset mid-sequence, then a full fresh sequence.
    dut_log.delete();
    use_tbl = 1'b1;
    run_seq(10'h000, 10'd256, 10'd512, 10'd768);
    wait_log(10);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_valid", base_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_last", base_last, 0);
    chk("midrst_done", done, 0);
    chk("midrst_base", base_out, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dut_log.delete();
    run_seq(10'h000, 10'd256, 10'd512, 10'd768);
    wait_done("restart");
    chk("restart_count", dut_log.size(), 64);
    chk("restart_pattern_bad", bad_tbl(64), 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
